// File: rtl/approx_mul_if.sv
// Stream bundle for approx_mul_pipe: operand pairs in, approximate products out.
// Valid/ready: a beat moves on a rising edge only when valid & ready are both 1;
// the producer keeps valid and payload stable until that edge, ready may depend on state.
interface approx_mul_if #(
    parameter int W = 8
) ();
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] prod;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, prod
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, prod
    );
endinterface

// File: rtl/approx_mul_pipe.sv
// Three-stage quadrant-split approximate multiplier with a per-quadrant mode register
// snapshotted at acceptance; all stages shift together on a single advance enable.
module approx_mul_pipe #(
    parameter int         W       = 8,
    parameter int         T       = 2,
    parameter logic [7:0] CFG_RST = 8'h00
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [7:0]       cfg_data,
    output logic [7:0]       cfg_mode,
    output logic [15:0]      done_cnt,
    approx_mul_if.slave      bus
);
    localparam int         H     = W / 2;
    localparam logic [W-1:0] TMASK = ~((W'(1) << T) - W'(1));
    localparam logic [W-1:0] BIAS  = W'(1) << (T - 1);

    logic           adv;
    logic [7:0]     cfg_mode_q, cfg_mode_d;
    logic [15:0]    done_cnt_q, done_cnt_d;

    logic           s1_valid_q, s1_valid_d;
    logic [W-1:0]   s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [7:0]     s1_mode_q, s1_mode_d;

    logic           s2_valid_q, s2_valid_d;
    logic [W-1:0]   s2_hh_q, s2_hh_d, s2_hl_q, s2_hl_d;
    logic [W-1:0]   s2_lh_q, s2_lh_d, s2_ll_q, s2_ll_d;

    logic           out_valid_q, out_valid_d;
    logic [2*W-1:0] prod_q, prod_d;

    logic [W:0]     mid_sum;
    logic [2*W-1:0] full_sum;

    function automatic logic [W-1:0] quad_mul(input logic [H-1:0] x, input logic [H-1:0] y);
        return {{(W-H){1'b0}}, x} * {{(W-H){1'b0}}, y};
    endfunction

    // Bias is added after truncation; with at least one cleared LSB it cannot overflow.
    function automatic logic [W-1:0] apply_mode(input logic [1:0] m, input logic [W-1:0] p);
        case (m)
            2'b00:   return p;
            2'b01:   return p & TMASK;
            2'b10:   return (p & TMASK) + BIAS;
            default: return '0;
        endcase
    endfunction

    assign adv           = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.prod      = prod_q;
    assign cfg_mode      = cfg_mode_q;
    assign done_cnt      = done_cnt_q;

    assign mid_sum  = {1'b0, s2_hl_q} + {1'b0, s2_lh_q};
    assign full_sum = {s2_hh_q, {W{1'b0}}}
                    + ({{(W-1){1'b0}}, mid_sum} << H)
                    + {{W{1'b0}}, s2_ll_q};

    always_comb begin
        cfg_mode_d  = cfg_we ? cfg_data : cfg_mode_q;
        done_cnt_d  = done_cnt_q + {15'd0, out_valid_q && bus.out_ready};

        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_mode_d   = s1_mode_q;
        s2_valid_d  = s2_valid_q;
        s2_hh_d     = s2_hh_q;
        s2_hl_d     = s2_hl_q;
        s2_lh_d     = s2_lh_q;
        s2_ll_d     = s2_ll_q;
        out_valid_d = out_valid_q;
        prod_d      = prod_q;

        if (adv) begin
            s1_valid_d  = bus.in_valid;
            s2_valid_d  = s1_valid_q;
            out_valid_d = s2_valid_q;
            if (bus.in_valid) begin
                s1_a_d    = bus.a;
                s1_b_d    = bus.b;
                s1_mode_d = cfg_mode_q;
            end
            if (s1_valid_q) begin
                s2_hh_d = apply_mode(s1_mode_q[7:6], quad_mul(s1_a_q[W-1:H], s1_b_q[W-1:H]));
                s2_hl_d = apply_mode(s1_mode_q[5:4], quad_mul(s1_a_q[W-1:H], s1_b_q[H-1:0]));
                s2_lh_d = apply_mode(s1_mode_q[3:2], quad_mul(s1_a_q[H-1:0], s1_b_q[W-1:H]));
                s2_ll_d = apply_mode(s1_mode_q[1:0], quad_mul(s1_a_q[H-1:0], s1_b_q[H-1:0]));
            end
            // prod only moves when a real result lands, so it holds across bubbles.
            if (s2_valid_q) begin
                prod_d = full_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_mode_q  <= CFG_RST;
            done_cnt_q  <= '0;
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_mode_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_hh_q     <= '0;
            s2_hl_q     <= '0;
            s2_lh_q     <= '0;
            s2_ll_q     <= '0;
            out_valid_q <= 1'b0;
            prod_q      <= '0;
        end else begin
            cfg_mode_q  <= cfg_mode_d;
            done_cnt_q  <= done_cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_mode_q   <= s1_mode_d;
            s2_valid_q  <= s2_valid_d;
            s2_hh_q     <= s2_hh_d;
            s2_hl_q     <= s2_hl_d;
            s2_lh_q     <= s2_lh_d;
            s2_ll_q     <= s2_ll_d;
            out_valid_q <= out_valid_d;
            prod_q      <= prod_d;
        end
    end
endmodule

// File: doc/approx_mul_pipe.md
Name: approx_mul_pipe

Overview:
- Parametrised, pipelined successor to the fixed 8x8 quadrant-split approximate multiplier.
- Splits each W-bit unsigned operand into high/low halves (H = W/2) and forms four partial products: hh, hl, lh, ll.
- Each quadrant's approximation mode is chosen at run time through a config register; the four products are summed exactly.
- Sits in the datapath behind a valid/ready stream interface and counts completed results.

Parameters:
- W, 8, operand width; even, 4..32.
- T, 2, number of truncated LSBs per partial product; 1 <= T <= W-1.
- CFG_RST, 8'h00, reset value of the mode register (all quadrants exact).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- cfg_we  in  1  write strobe for the mode register
- cfg_data  in  8  new mode: [1:0] ll, [3:2] lh, [5:4] hl, [7:6] hh
- cfg_mode  out  8  current mode register
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- a  in  W  multiplicand, unsigned
- b  in  W  multiplier, unsigned
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- prod  out  2W  approximate product
- done_cnt  out  16  count of results consumed (out_valid & out_ready), wraps 16'hFFFF -> 0

Behaviour:
- Reset (rst_n=0 at a clk edge), synchronous:
  - all stage valids = 0, out_valid = 0, prod = 0;
  - cfg_mode = CFG_RST, done_cnt = 0;
  - in-flight data is discarded; in_ready = 1 in the first cycle after reset.
- Quadrant products are W-bit: hh = ah*bh, hl = ah*bl, lh = al*bh, ll = al*bl.
- Mode per quadrant, applied to its exact product p:
  - 00: exact, p.
  - 01: truncate, p with its low T bits forced to 0.
  - 10: truncate plus bias, (truncated p) + 2^(T-1). Always added, including for p = 0. Cannot overflow W bits.
  - 11: drop, quadrant value = 0.
- Sum: prod = (hh' << W) + ((hl' + lh') << H) + ll'. Exact addition, 2W-bit result; any carry beyond 2W is discarded (it cannot occur for modes 00/01).
- Pipeline, 3 register stages:
  - S1 captures a, b and a snapshot of cfg_mode.
  - S2 holds the four modified partial products.
  - S3 holds prod and out_valid.
- Advance enable: adv = !out_valid | out_ready. All stages shift together when adv=1 and hold when adv=0. in_ready = adv (combinational).
- Latency: a transfer accepted at edge t (in_valid & in_ready) presents out_valid=1 with its prod after edge t+2, with no stalls. Throughput is 1 per cycle.
- Bubbles (in_valid=0 at an advancing edge) propagate as invalid stages. prod holds its last value while out_valid=0.
- Backpressure: while out_valid=1 and out_ready=0, prod and all stages hold and in_ready=0. No result is dropped or duplicated.
- Config timing:
  - cfg_we=1 updates cfg_mode at that edge.
  - A transfer accepted on the same edge uses the old mode; transfers accepted afterwards use the new one.
  - In-flight transfers always keep their snapshot.
- done_cnt increments at each edge where out_valid & out_ready.
- Reset takes priority over cfg_we and transfers on the same edge.

Test Plan:
1. Exact mode: CFG_RST=00, W=8, T=2, a=200, b=150, out_ready=1 -> after 3 cycles prod=16'h7530 (30000), out_valid for 1 cycle, done_cnt=1.
2. All-truncate: cfg_data=8'h55, a=b=8'hFF -> prod=64736. All-bias: cfg_data=8'hAA, same operands -> prod=65314.
3. Drop ll only: cfg_data=8'h03, a=b=8'h0F -> prod=0. With a=b=8'hF0 under the same mode -> prod=57600 (exact).
4. Backpressure: 5 back-to-back transfers (a=1..5, b=3) with out_ready=0 -> out_valid=1 with prod=3 held, and in_ready=0 from the first stall. Then raising out_ready yields 3, 6, 9, 12, 15 in order, with no loss or duplication; done_cnt=5.
5. Config race: cfg_we=1 with 8'h55 on the same edge as accepting a=b=8'hFF -> that result is 65025 (old exact mode); the next transfer with the same operands -> 64736.
6. Reset mid-stream: rst_n=0 for one edge with 2 transfers in flight -> out_valid=0, prod=0, cfg_mode=CFG_RST, done_cnt=0, and no stale result appears afterwards. A separate run forces 65536 consumed results and checks that done_cnt wraps to 0.
